// File: rtl/pdp8_bus_target.sv
// Bus target for the PDP-8 byte-serial CPU bus: decodes address/IO/data beats and
// bridges them to a 12-bit memory port and a 12-bit IO device port.
module pdp8_bus_target #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_in,
  output logic [3:0]  bus_data,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  input  logic [11:0] mem_rdata,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  output logic [5:0]  io_dev,
  output logic [2:0]  io_fn,
  output logic        io_re,
  input  logic [11:0] io_rdata,
  output logic        io_we,
  output logic [11:0] io_wdata,
  input  logic        io_ready_in,
  input  logic        io_skip_in,
  input  logic        int_req_in,
  output logic        proto_err
);

  localparam int unsigned WORD_W = 12;
  localparam int unsigned HALF_W = 6;
  localparam bit          LAT1   = (RD_LATENCY != 0);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ADDR_LO_SEEN = 3'd1;
  localparam logic [2:0] S_ADDR_DONE    = 3'd2;
  localparam logic [2:0] S_IO           = 3'd3;
  localparam logic [2:0] S_D_HI         = 3'd4;
  localparam logic [2:0] S_D_MID        = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [HALF_W-1:0] alo_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] rbuf_q;
  logic [WORD_W-1:0] wdata_q;
  logic [7:0]        wd_q;
  logic              wr_q;
  logic              io_cyc_q;
  logic [HALF_W-1:0] io_dev_q;
  logic [2:0]        io_fn_q;
  logic              re_q;
  logic              mem_we_q;
  logic              io_we_q;
  logic              perr_q;

  logic is_alo, is_ahi, is_io, is_dhi, is_dmid, is_dlo, wbit;
  logic err_c, take_hi, take_io, take_dhi, take_dmid, take_dlo;

  // Beat classification; 011x1xxx matches nothing and is always illegal.
  assign is_alo  = (bus_in[7:6] == 2'b10);
  assign is_ahi  = (bus_in[7:6] == 2'b11);
  assign is_io   = (bus_in[7:5] == 3'b011) && !bus_in[3];
  assign is_dhi  = (bus_in[7:5] == 3'b000);
  assign is_dmid = (bus_in[7:5] == 3'b001);
  assign is_dlo  = (bus_in[7:5] == 3'b010);
  assign wbit    = bus_in[4];

  // Next-state: an addr[5:0] beat always restarts; anything out of order errors to IDLE.
  always_comb begin
    state_d   = state_q;
    err_c     = 1'b0;
    take_hi   = 1'b0;
    take_io   = 1'b0;
    take_dhi  = 1'b0;
    take_dmid = 1'b0;
    take_dlo  = 1'b0;
    if (is_alo) begin
      state_d = S_ADDR_LO_SEEN;
    end else begin
      case (state_q)
        S_ADDR_LO_SEEN: begin
          if (is_ahi) begin
            take_hi = 1'b1;
            state_d = S_ADDR_DONE;
          end else err_c = 1'b1;
        end
        S_ADDR_DONE: begin
          if (is_io) begin
            take_io = 1'b1;
            state_d = S_IO;
          end else if (is_dhi) begin
            take_dhi = 1'b1;
            state_d  = S_D_HI;
          end else err_c = 1'b1;
        end
        S_IO: begin
          if (is_dhi) begin
            take_dhi = 1'b1;
            state_d  = S_D_HI;
          end else err_c = 1'b1;
        end
        S_D_HI: begin
          if (is_dmid && (wbit == wr_q)) begin
            take_dmid = 1'b1;
            state_d   = S_D_MID;
          end else err_c = 1'b1;
        end
        S_D_MID: begin
          if (is_dlo && (wbit == wr_q)) begin
            take_dlo = 1'b1;
            state_d  = S_IDLE;
          end else err_c = 1'b1;
        end
        default: err_c = 1'b1;
      endcase
      if (err_c) state_d = S_IDLE;
    end
  end

  // Beat-time responses; the data-hi beat right after addr[11:6] sees memory data directly.
  always_comb begin
    bus_data = 4'h0;
    mem_re   = 1'b0;
    io_re    = 1'b0;
    mem_addr = addr_q;
    io_dev   = io_dev_q;
    io_fn    = io_fn_q;
    if (take_hi) begin
      mem_re   = 1'b1;
      mem_addr = {bus_in[5:0], alo_q};
    end
    if (take_io) begin
      io_dev   = addr_q[5:0];
      io_fn    = bus_in[2:0];
      io_re    = !wbit;
      bus_data = {1'b0, int_req_in, io_skip_in, io_ready_in};
    end
    if (!wbit) begin
      if (take_dhi)  bus_data = (LAT1 && re_q) ? mem_rdata[11:8] : rbuf_q[11:8];
      if (take_dmid) bus_data = rbuf_q[7:4];
      if (take_dlo)  bus_data = rbuf_q[3:0];
    end
    if (reset) begin
      bus_data = 4'h0;
      mem_re   = 1'b0;
      io_re    = 1'b0;
      mem_addr = '0;
      io_dev   = '0;
      io_fn    = '0;
    end
  end

  assign mem_we    = mem_we_q & ~reset;
  assign io_we     = io_we_q & ~reset;
  assign proto_err = perr_q & ~reset;
  assign mem_wdata = wdata_q;
  assign io_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      alo_q    <= '0;
      addr_q   <= '0;
      rbuf_q   <= '0;
      wdata_q  <= '0;
      wd_q     <= '0;
      wr_q     <= 1'b0;
      io_cyc_q <= 1'b0;
      io_dev_q <= '0;
      io_fn_q  <= '0;
      re_q     <= 1'b0;
      mem_we_q <= 1'b0;
      io_we_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      re_q     <= take_hi;
      mem_we_q <= take_dlo & wbit & ~io_cyc_q;
      io_we_q  <= take_dlo & wbit & io_cyc_q;
      perr_q   <= perr_q | err_c;
      if (is_alo) begin
        alo_q    <= bus_in[5:0];
        io_cyc_q <= 1'b0;
      end
      if (take_hi) addr_q <= {bus_in[5:0], alo_q};
      if (take_io) begin
        io_cyc_q <= 1'b1;
        io_dev_q <= addr_q[5:0];
        io_fn_q  <= bus_in[2:0];
      end
      // IO read data wins over the speculative memory read landing in the same cycle.
      if (take_io && !wbit) rbuf_q <= io_rdata;
      else if (LAT1 ? re_q : take_hi) rbuf_q <= mem_rdata;
      if (take_dhi) begin
        wr_q      <= wbit;
        wd_q[7:4] <= bus_in[3:0];
      end
      if (take_dmid) wd_q[3:0] <= bus_in[3:0];
      if (take_dlo && wbit) wdata_q <= {wd_q, bus_in[3:0]};
    end
  end

endmodule

// File: tb/tb_pdp8_bus_target.sv
// Bench for pdp8_bus_target: directed protocol scenarios plus random back-to-back
// transactions checked against a transaction-level expectation.
module tb_pdp8_bus_target;

  logic        clk;
  logic        reset;
  logic [7:0]  bus_in;
  logic [3:0]  bus_data;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [11:0] mem_rdata;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [5:0]  io_dev;
  logic [2:0]  io_fn;
  logic        io_re;
  logic [11:0] io_rdata;
  logic        io_we;
  logic [11:0] io_wdata;
  logic        io_ready_in, io_skip_in, int_req_in;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int n_mre = 0, n_mwe = 0, n_ire = 0, n_iwe = 0;

  logic [11:0] dev_mem [4096];
  logic        rd_v;
  logic [11:0] rd_addr, garbage;

  pdp8_bus_target dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_data(bus_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .io_dev(io_dev), .io_fn(io_fn), .io_re(io_re), .io_rdata(io_rdata),
    .io_we(io_we), .io_wdata(io_wdata),
    .io_ready_in(io_ready_in), .io_skip_in(io_skip_in), .int_req_in(int_req_in),
    .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle-latency memory: valid data only in the cycle after mem_re, noise otherwise.
  always @(posedge clk) begin
    if (reset) rd_v <= 1'b0;
    else rd_v <= mem_re;
    rd_addr <= mem_addr;
    garbage <= 12'($urandom);
  end
  assign mem_rdata = rd_v ? dev_mem[rd_addr] : garbage;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_re) n_mre++;
      if (mem_we) n_mwe++;
      if (io_re)  n_ire++;
      if (io_we)  n_iwe++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic [7:0] b);
    @(posedge clk); #1;
    bus_in = b;
    @(negedge clk); #1;
  endtask

  task automatic apply_reset;
    @(posedge clk); #1;
    reset = 1'b1; bus_in = 8'h80;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if ({bus_data, mem_re, mem_we, io_re, io_we, proto_err} !== 9'h0) begin
        errors++;
        $display("FAIL reset_outs got %h want 0", {bus_data, mem_re, mem_we, io_re, io_we, proto_err});
      end
      checks++;
      if (mem_addr !== 12'h000) begin
        errors++; $display("FAIL reset_addr got %h want 000", mem_addr);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; bus_in = 8'h80;
    @(negedge clk); #1;
    checks++;
    if ({bus_data, proto_err, mem_re} !== 6'h0) begin
      errors++; $display("FAIL post_reset got %h want 0", {bus_data, proto_err, mem_re});
    end
  endtask

  task automatic test_spec_read;
    int re0, we0;
    re0 = n_mre; we0 = n_mwe;
    beat(8'h85);
    beat(8'hC2);
    checks++;
    if (mem_addr !== 12'h085 || mem_re !== 1'b1) begin
      errors++; $display("FAIL rd_addr got %h/%b want 085/1", mem_addr, mem_re);
    end
    beat(8'h00);
    checks++;
    if (bus_data !== 4'hA) begin errors++; $display("FAIL rd_hi got %h want A", bus_data); end
    beat(8'h20);
    checks++;
    if (bus_data !== 4'hB) begin errors++; $display("FAIL rd_mid got %h want B", bus_data); end
    beat(8'h40);
    checks++;
    if (bus_data !== 4'hC) begin errors++; $display("FAIL rd_lo got %h want C", bus_data); end
    beat(8'h80);
    checks++;
    if (n_mre - re0 != 1 || n_mwe != we0) begin
      errors++; $display("FAIL rd_strobes re %0d we %0d want 1 0", n_mre - re0, n_mwe - we0);
    end
  endtask

  task automatic test_spec_write;
    int we0, iw0, ir0;
    we0 = n_mwe; iw0 = n_iwe; ir0 = n_ire;
    beat(8'h81); beat(8'hC0); beat(8'h1F); beat(8'h31); beat(8'h52);
    checks++;
    if (mem_we !== 1'b0 || bus_data !== 4'h0) begin
      errors++; $display("FAIL wr_early we %b bd %h want 0 0", mem_we, bus_data);
    end
    beat(8'h80);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h001 || mem_wdata !== 12'hF12) begin
      errors++; $display("FAIL wr_strobe got %b %h %h want 1 001 F12", mem_we, mem_addr, mem_wdata);
    end
    beat(8'h80);
    checks++;
    if (n_mwe - we0 != 1 || n_iwe != iw0 || n_ire != ir0) begin
      errors++; $display("FAIL wr_count mwe %0d iwe %0d ire %0d want 1 0 0", n_mwe - we0, n_iwe - iw0, n_ire - ir0);
    end
  endtask

  task automatic test_io_read;
    int we0, ir0;
    we0 = n_mwe; ir0 = n_ire;
    io_ready_in = 1'b1; int_req_in = 1'b1; io_skip_in = 1'b0; io_rdata = 12'h123;
    beat(8'h83); beat(8'hC0);
    beat(8'h64);
    checks++;
    if (bus_data !== 4'h5 || io_dev !== 6'd3 || io_fn !== 3'd4 || io_re !== 1'b1) begin
      errors++; $display("FAIL io_intro got %h %h %h %b want 5 03 4 1", bus_data, io_dev, io_fn, io_re);
    end
    beat(8'h00);
    checks++;
    if (bus_data !== 4'h1) begin errors++; $display("FAIL io_hi got %h want 1", bus_data); end
    beat(8'h20);
    checks++;
    if (bus_data !== 4'h2) begin errors++; $display("FAIL io_mid got %h want 2", bus_data); end
    beat(8'h40);
    checks++;
    if (bus_data !== 4'h3) begin errors++; $display("FAIL io_lo got %h want 3", bus_data); end
    beat(8'h80);
    checks++;
    if (n_ire - ir0 != 1 || n_mwe != we0) begin
      errors++; $display("FAIL io_count ire %0d mwe %0d want 1 0", n_ire - ir0, n_mwe - we0);
    end
  endtask

  task automatic test_resync;
    int we0, iw0;
    we0 = n_mwe; iw0 = n_iwe;
    beat(8'h81); beat(8'hC0); beat(8'h1F); beat(8'h80);
    beat(8'hC1);
    checks++;
    if (mem_addr !== 12'h040 || mem_we !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL resync got %h %b %b want 040 0 0", mem_addr, mem_we, proto_err);
    end
    beat(8'h80);
    checks++;
    if (n_mwe != we0 || n_iwe != iw0) begin
      errors++; $display("FAIL resync_strobe mwe %0d iwe %0d want 0 0", n_mwe - we0, n_iwe - iw0);
    end
  endtask

  task automatic test_error;
    int we0;
    @(posedge clk); #1;
    reset = 1'b1; bus_in = 8'h80;
    @(posedge clk); #1;
    reset = 1'b0; bus_in = 8'h20;
    @(negedge clk); #1;
    checks++;
    if (bus_data !== 4'h0) begin errors++; $display("FAIL err_idle_bd got %h want 0", bus_data); end
    beat(8'h80);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", proto_err); end
    beat(8'h85); beat(8'hC2); beat(8'h00);
    checks++;
    if (bus_data !== 4'hA) begin errors++; $display("FAIL err_after_rd got %h want A", bus_data); end
    beat(8'h20); beat(8'h40); beat(8'h80);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", proto_err); end
    apply_reset();
    beat(8'h80);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", proto_err); end
    // Mid beat without hi: must not leak read-buffer data.
    beat(8'h85); beat(8'hC2); beat(8'h20);
    checks++;
    if (bus_data !== 4'h0) begin errors++; $display("FAIL err_order_bd got %h want 0", bus_data); end
    beat(8'h80);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL err_order got %b want 1", proto_err); end
    apply_reset();
    beat(8'h85); beat(8'hC2); beat(8'h78); beat(8'h80);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL err_illegal got %b want 1", proto_err); end
    apply_reset();
    we0 = n_mwe;
    beat(8'h81); beat(8'hC0); beat(8'h1F); beat(8'h21); beat(8'h40); beat(8'h80); beat(8'h80);
    checks++;
    if (proto_err !== 1'b1 || n_mwe != we0) begin
      errors++; $display("FAIL err_wflip perr %b mwe %0d want 1 0", proto_err, n_mwe - we0);
    end
    apply_reset();
    we0 = n_mwe;
    beat(8'h81); beat(8'hC0); beat(8'h1F); beat(8'h31);
    @(posedge clk); #1;
    reset = 1'b1; bus_in = 8'h52;
    @(posedge clk); #1;
    reset = 1'b0; bus_in = 8'h80;
    beat(8'h80); beat(8'h80);
    checks++;
    if (n_mwe != we0) begin errors++; $display("FAIL rst_midwr mwe %0d want 0", n_mwe - we0); end
    beat(8'h81); beat(8'hC0); beat(8'h1F); beat(8'h31); beat(8'h52);
    @(posedge clk); #1;
    reset = 1'b1; bus_in = 8'h80;
    @(negedge clk); #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_pend got %b want 0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    beat(8'h80);
    checks++;
    if (mem_we !== 1'b0 || n_mwe != we0) begin
      errors++; $display("FAIL rst_pend_after we %b cnt %0d want 0 0", mem_we, n_mwe - we0);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [1:0]  pend;
    logic [11:0] p_addr, p_data;
    logic [5:0]  p_dev;
    logic [2:0]  p_fn;
    logic        io, wr;
    logic [11:0] a, d, rv;
    logic [2:0]  fn, st;
    logic [3:0]  exp_nib;
    int nfill, e_mre, e_mwe, e_ire, e_iwe, b_mre, b_mwe, b_ire, b_iwe;
    apply_reset();
    pend = 2'd0; p_addr = '0; p_data = '0; p_dev = '0; p_fn = '0;
    e_mre = 0; e_mwe = 0; e_ire = 0; e_iwe = 0;
    b_mre = n_mre; b_mwe = n_mwe; b_ire = n_ire; b_iwe = n_iwe;
    for (int t = 0; t <= n; t++) begin
      io = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 12'($urandom);
      d  = 12'($urandom);
      fn = 3'($urandom);
      st = 3'($urandom);
      io_ready_in = st[0]; io_skip_in = st[1]; int_req_in = st[2];
      io_rdata = 12'($urandom);
      rv = io ? io_rdata : dev_mem[a];
      nfill = $urandom_range(0, 2);
      for (int k = 0; k <= nfill; k++) begin
        if (t == n || k < nfill) beat({2'b10, 6'($urandom)});
        else beat({2'b10, a[5:0]});
        if (k == 0) begin
          checks++;
          if (mem_we !== (pend == 2'd1) || io_we !== (pend == 2'd2)) begin
            errors++; $display("FAIL b2b_strobe t=%0d got %b%b want kind %0d", t, mem_we, io_we, pend);
          end
          if (pend == 2'd1) begin
            checks++;
            if (mem_addr !== p_addr || mem_wdata !== p_data) begin
              errors++; $display("FAIL b2b_mwr t=%0d got %h %h want %h %h", t, mem_addr, mem_wdata, p_addr, p_data);
            end
          end
          if (pend == 2'd2) begin
            checks++;
            if (io_wdata !== p_data || io_dev !== p_dev || io_fn !== p_fn) begin
              errors++; $display("FAIL b2b_iwr t=%0d got %h %h %h want %h %h %h", t, io_wdata, io_dev, io_fn, p_data, p_dev, p_fn);
            end
          end
          pend = 2'd0;
        end
        checks++;
        if (bus_data !== 4'h0) begin errors++; $display("FAIL b2b_alo_bd t=%0d got %h want 0", t, bus_data); end
        if (t == n) break;
      end
      if (t == n) break;
      beat({2'b11, a[11:6]});
      checks++;
      if (mem_re !== 1'b1 || mem_addr !== a || bus_data !== 4'h0) begin
        errors++; $display("FAIL b2b_ahi t=%0d got %b %h %h want 1 %h 0", t, mem_re, mem_addr, bus_data, a);
      end
      e_mre++;
      if (io) begin
        beat({3'b011, wr, 1'b0, fn});
        checks++;
        if (bus_data !== {1'b0, st[2], st[1], st[0]} || io_re !== !wr || io_dev !== a[5:0] || io_fn !== fn) begin
          errors++; $display("FAIL b2b_intro t=%0d got %h %b %h %h want %h %b %h %h",
                             t, bus_data, io_re, io_dev, io_fn, {1'b0, st}, !wr, a[5:0], fn);
        end
        if (!wr) e_ire++;
      end
      for (int j = 0; j < 3; j++) begin
        beat({1'b0, 2'(j), wr, 4'(d >> (8 - 4 * j))});
        exp_nib = wr ? 4'h0 : 4'(rv >> (8 - 4 * j));
        checks++;
        if (bus_data !== exp_nib) begin
          errors++; $display("FAIL b2b_data t=%0d j=%0d got %h want %h", t, j, bus_data, exp_nib);
        end
      end
      if (wr) begin
        pend = io ? 2'd2 : 2'd1;
        p_addr = a; p_data = d; p_dev = a[5:0]; p_fn = fn;
        if (io) e_iwe++;
        else e_mwe++;
      end
    end
    beat(8'h80);
    checks++;
    if (n_mre - b_mre != e_mre || n_mwe - b_mwe != e_mwe || n_ire - b_ire != e_ire || n_iwe - b_iwe != e_iwe) begin
      errors++; $display("FAIL b2b_counts got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         n_mre - b_mre, n_mwe - b_mwe, n_ire - b_ire, n_iwe - b_iwe, e_mre, e_mwe, e_ire, e_iwe);
    end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_perr got %b want 0", proto_err); end
  endtask

  initial begin
    reset = 1'b1;
    bus_in = 8'hC5;
    io_ready_in = 1'b0; io_skip_in = 1'b0; int_req_in = 1'b0;
    io_rdata = 12'h000;
    for (int i = 0; i < 4096; i++) dev_mem[i] = 12'($urandom);
    dev_mem[12'h085] = 12'hABC;
    test_reset();
    test_spec_read();
    test_spec_write();
    test_io_read();
    test_resync();
    test_error();
    test_back_to_back(80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
